// File: rtl/disk_block_responder_pkg.sv
// Shared constants and FSM encodings for the disk block responder.
package disk_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned SECTOR_LOG2  = 9;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ACCEPT   = 3'd1;
    localparam state_t ST_RD_FETCH = 3'd2;
    localparam state_t ST_RD_PUT   = 3'd3;
    localparam state_t ST_WR_ADDR  = 3'd4;
    localparam state_t ST_WR_WAIT  = 3'd5;
    localparam state_t ST_WR_STORE = 3'd6;
    localparam state_t ST_DONE     = 3'd7;

endpackage

// File: rtl/disk_block_responder_if.sv
// Sector request handshake, sector buffer port and backing-store port.
interface disk_block_responder_if
    import disk_pkg::*;
#(
    parameter int unsigned VDNUM  = 3,
    parameter int unsigned MEM_AW = 27
);

    logic [31:0]            sd_lba;
    logic [VDNUM-1:0]       sd_rd;
    logic [VDNUM-1:0]       sd_wr;
    logic                   sd_ack;
    logic [SECTOR_LOG2-1:0] sd_buff_addr;
    logic [7:0]             sd_buff_dout;
    logic                   sd_buff_wr;
    logic [7:0]             sd_buff_din;

    logic [MEM_AW-1:0]      mem_addr;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [7:0]             mem_din;
    logic [7:0]             mem_dout;
    logic                   mem_ready;

    // Environment side: request initiator, sector buffer and memory.
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_din
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_din
    );

endinterface

// File: rtl/disk_block_responder_arbiter.sv
// Fixed-priority pick of the pending drive request: lowest index wins, read before write.
module disk_req_arbiter #(
    parameter int unsigned VDNUM = 3
) (
    input  logic [VDNUM-1:0] rd,
    input  logic [VDNUM-1:0] wr,
    output logic             valid,
    output logic [1:0]       idx,
    output logic             is_wr
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        is_wr = 1'b0;
        for (int unsigned i = 0; i < VDNUM; i++) begin
            if (!valid && (rd[i] || wr[i])) begin
                valid = 1'b1;
                idx   = 2'(i);
                is_wr = !rd[i];
            end
        end
    end

endmodule

// File: rtl/disk_block_responder.sv
// Target side of the sector handshake: moves 512-byte sectors between the
// sector buffer and a byte-wide backing store holding per-drive disk images.
module disk_block_responder
    import disk_pkg::*;
#(
    parameter int unsigned VDNUM  = 3,
    parameter int unsigned MEM_AW = 27
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    disk_block_responder_if.slave     bus,
    input  logic [VDNUM*MEM_AW-1:0]   img_base,
    input  logic [VDNUM*32-1:0]       img_blocks,
    output logic                      busy,
    output logic [1:0]                drv
);

    state_t                 state;
    logic [SECTOR_LOG2-1:0] n;
    logic                   dir_wr;
    logic                   oor;
    logic [31:0]            lba_q;
    logic [MEM_AW-1:0]      base;
    logic [7:0]             data;

    logic                   req_valid;
    logic [1:0]             req_idx;
    logic                   req_wr;

    logic [MEM_AW-1:0]      sel_base;
    logic [31:0]            sel_blocks;
    logic [MEM_AW-1:0]      lba_off;
    logic                   oor_now;
    logic                   last;

    disk_req_arbiter #(.VDNUM(VDNUM)) u_arb (
        .rd    (bus.sd_rd),
        .wr    (bus.sd_wr),
        .valid (req_valid),
        .idx   (req_idx),
        .is_wr (req_wr)
    );

    always_comb begin
        sel_base   = img_base[32'(drv)*MEM_AW +: MEM_AW];
        sel_blocks = img_blocks[32'(drv)*32 +: 32];
    end

    assign lba_off = MEM_AW'({lba_q, {SECTOR_LOG2{1'b0}}});
    assign oor_now = (lba_q >= sel_blocks);
    assign last    = (n == SECTOR_LOG2'(SECTOR_BYTES - 1));

    assign bus.mem_addr     = base + MEM_AW'(n);
    assign bus.sd_buff_addr = n;
    assign bus.sd_buff_dout = data;
    assign busy             = (state != ST_IDLE);

    // Memory strobes are raised on entry to the access state so a zero-wait
    // memory completes in that state's single cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= ST_IDLE;
            n              <= '0;
            drv            <= '0;
            dir_wr         <= 1'b0;
            oor            <= 1'b0;
            lba_q          <= '0;
            base           <= '0;
            data           <= '0;
            bus.sd_ack     <= 1'b0;
            bus.sd_buff_wr <= 1'b0;
            bus.mem_rd     <= 1'b0;
            bus.mem_wr     <= 1'b0;
            bus.mem_din    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        drv    <= req_idx;
                        dir_wr <= req_wr;
                        lba_q  <= bus.sd_lba;
                        state  <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    base       <= sel_base + lba_off;
                    oor        <= oor_now;
                    n          <= '0;
                    bus.sd_ack <= 1'b1;
                    if (dir_wr) begin
                        state <= ST_WR_ADDR;
                    end else begin
                        bus.mem_rd <= !oor_now;
                        state      <= ST_RD_FETCH;
                    end
                end
                ST_RD_FETCH: begin
                    if (oor) begin
                        data           <= '0;
                        bus.sd_buff_wr <= 1'b1;
                        state          <= ST_RD_PUT;
                    end else if (bus.mem_rd && bus.mem_ready) begin
                        data           <= bus.mem_dout;
                        bus.mem_rd     <= 1'b0;
                        bus.sd_buff_wr <= 1'b1;
                        state          <= ST_RD_PUT;
                    end
                end
                ST_RD_PUT: begin
                    bus.sd_buff_wr <= 1'b0;
                    if (last) begin
                        bus.sd_ack <= 1'b0;
                        state      <= ST_DONE;
                    end else begin
                        n          <= n + 1'b1;
                        bus.mem_rd <= !oor;
                        state      <= ST_RD_FETCH;
                    end
                end
                ST_WR_ADDR: begin
                    state <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    bus.mem_din <= bus.sd_buff_din;
                    bus.mem_wr  <= !oor;
                    state       <= ST_WR_STORE;
                end
                ST_WR_STORE: begin
                    if (oor || (bus.mem_wr && bus.mem_ready)) begin
                        bus.mem_wr <= 1'b0;
                        if (last) begin
                            bus.sd_ack <= 1'b0;
                            state      <= ST_DONE;
                        end else begin
                            n     <= n + 1'b1;
                            state <= ST_WR_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disk_block_responder.sv
// Directed bench for disk_block_responder with buffer/memory models and scoreboard queues.
module tb_disk_block_responder;

    typedef struct packed {
        logic [8:0] a;
        logic [7:0] d;
    } bexp_t;

    typedef struct packed {
        logic        wr;
        logic [26:0] a;
        logic [7:0]  d;
    } mexp_t;

    logic        clk;
    logic        rst_n;
    logic [80:0] img_base;
    logic [95:0] img_blocks;
    logic        busy;
    logic [1:0]  drv;

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          cnt;
    int          rd_cycles;
    int          wr_cycles;
    logic        preload = 1'b0;
    logic [7:0]  buf_mem [512];
    bexp_t       buf_q [$];
    mexp_t       mem_q [$];

    disk_block_responder_if #(.VDNUM(3), .MEM_AW(27)) bus ();

    disk_block_responder #(.VDNUM(3), .MEM_AW(27)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .bus        (bus),
        .img_base   (img_base),
        .img_blocks (img_blocks),
        .busy       (busy),
        .drv        (drv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sector buffer: registered read, data valid one cycle after the address.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) buf_mem[i] <= 8'(i);
        end else if (bus.sd_buff_wr) begin
            buf_mem[bus.sd_buff_addr] <= bus.sd_buff_dout;
        end
        bus.sd_buff_din <= buf_mem[bus.sd_buff_addr];
    end

    // Backing store: completes each access 'lat' cycles after the strobe is seen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_ready <= 1'b0;
            bus.mem_dout  <= '0;
            cnt           <= 0;
        end else begin
            bus.mem_ready <= 1'b0;
            if ((bus.mem_rd || bus.mem_wr) && !bus.mem_ready) begin
                if (cnt + 1 >= lat) begin
                    bus.mem_ready <= 1'b1;
                    bus.mem_dout  <= bus.mem_addr[7:0] ^ 8'h5A;
                    cnt           <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end else begin
                cnt <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_read(input logic [26:0] a0, input logic zero, input int count);
        for (int i = 0; i < count; i++) begin
            logic [26:0] a;
            a = a0 + 27'(i);
            buf_q.push_back('{a: 9'(i), d: (zero ? 8'h00 : (a[7:0] ^ 8'h5A))});
            if (!zero) mem_q.push_back('{wr: 1'b0, a: a, d: 8'h00});
        end
    endtask

    task automatic exp_write(input logic [26:0] a0);
        for (int i = 0; i < 512; i++) begin
            mem_q.push_back('{wr: 1'b1, a: a0 + 27'(i), d: 8'(i)});
        end
    endtask

    task automatic wait_ack(input logic level, input int maxc, input string tag);
        int c;
        c = 0;
        while (bus.sd_ack !== level && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(tag, bus.sd_ack, level);
    endtask

    task automatic xfer(input logic [2:0] rd, input logic [2:0] wr, input logic [1:0] exp_drv, input string tag);
        bus.sd_rd = rd;
        bus.sd_wr = wr;
        wait_ack(1'b1, 50, {tag, "_ack_rise"});
        chk({tag, "_drv"}, drv, exp_drv);
        bus.sd_rd = '0;
        bus.sd_wr = '0;
        wait_ack(1'b0, 20000, {tag, "_ack_fall"});
        chk({tag, "_buf_left"}, buf_q.size(), 0);
        chk({tag, "_mem_left"}, mem_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic monitor();
        logic        prev;
        logic [26:0] a0;
        int          held;
        bexp_t       e;
        mexp_t       m;
        prev = 1'b0;
        a0   = '0;
        held = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_rd) rd_cycles++;
            if (bus.mem_wr) wr_cycles++;
            if (bus.mem_rd || bus.mem_wr) begin
                if (!prev) begin
                    a0   = bus.mem_addr;
                    held = 0;
                end
                held++;
            end
            if (bus.sd_buff_wr) begin
                chk("buff_wr_expected", buf_q.size() != 0, 1'b1);
                if (buf_q.size() != 0) begin
                    e = buf_q.pop_front();
                    chk("buff_addr", bus.sd_buff_addr, e.a);
                    chk("buff_data", bus.sd_buff_dout, e.d);
                end
            end
            if (bus.mem_ready && (bus.mem_rd || bus.mem_wr)) begin
                chk("mem_exclusive", bus.mem_rd & bus.mem_wr, 1'b0);
                chk("mem_expected", mem_q.size() != 0, 1'b1);
                if (mem_q.size() != 0) begin
                    m = mem_q.pop_front();
                    chk("mem_dir", bus.mem_wr, m.wr);
                    chk("mem_addr", bus.mem_addr, m.a);
                    chk("mem_addr_stable", a0, m.a);
                    chk("mem_hold", held >= lat, 1'b1);
                    if (m.wr) chk("mem_din", bus.mem_din, m.d);
                end
            end
            prev = bus.mem_rd || bus.mem_wr;
        end
    endtask

    initial begin
        logic seen_idle;
        int   c;
        rst_n      = 1'b0;
        bus.sd_rd  = '0;
        bus.sd_wr  = '0;
        bus.sd_lba = '0;
        img_base   = '0;
        img_blocks = '0;
        rd_cycles  = 0;
        wr_cycles  = 0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_ack", bus.sd_ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_rd", bus.mem_rd, 1'b0);
        chk("rst_mem_wr", bus.mem_wr, 1'b0);
        chk("rst_buff_wr", bus.sd_buff_wr, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 27'h0);
        chk("rst_drv", drv, 2'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read drive 0, sector 2.
        img_base[0 +: 27]   = 27'h0;
        img_blocks[0 +: 32] = 32'd720;
        bus.sd_lba = 32'd2;
        exp_read(27'h400, 1'b0, 512);
        xfer(3'b001, 3'b000, 2'd0, "rd0");

        // Write drive 1, sector 0, buffer holding n[7:0].
        img_base[27 +: 27]   = 27'h100000;
        img_blocks[32 +: 32] = 32'd720;
        bus.sd_lba = 32'd0;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        exp_write(27'h100000);
        xfer(3'b000, 3'b010, 2'd1, "wr1");

        // Simultaneous requests on drives 0 and 2.
        img_base[54 +: 27]   = 27'h200000;
        img_blocks[64 +: 32] = 32'd720;
        bus.sd_lba = 32'd3;
        exp_read(27'h600, 1'b0, 512);
        exp_read(27'h200600, 1'b0, 512);
        bus.sd_rd = 3'b101;
        wait_ack(1'b1, 50, "pri_ack0_rise");
        chk("pri_drv0", drv, 2'd0);
        bus.sd_rd = 3'b100;
        wait_ack(1'b0, 20000, "pri_ack0_fall");
        seen_idle = 1'b0;
        c = 0;
        while (bus.sd_ack !== 1'b1 && c < 50) begin
            if (!busy) seen_idle = 1'b1;
            @(negedge clk);
            c++;
        end
        chk("pri_ack2_rise", bus.sd_ack, 1'b1);
        chk("pri_idle_gap", seen_idle, 1'b1);
        chk("pri_drv2", drv, 2'd2);
        bus.sd_rd = '0;
        wait_ack(1'b0, 20000, "pri_ack2_fall");
        chk("pri_buf_left", buf_q.size(), 0);
        chk("pri_mem_left", mem_q.size(), 0);
        repeat (3) @(negedge clk);

        // Out-of-range sector: zeros on read, dropped bytes on write.
        bus.sd_lba = 32'd720;
        rd_cycles  = 0;
        exp_read(27'h0, 1'b1, 512);
        xfer(3'b001, 3'b000, 2'd0, "oor_rd");
        chk("oor_rd_no_mem_rd", rd_cycles, 0);
        wr_cycles = 0;
        xfer(3'b000, 3'b001, 2'd0, "oor_wr");
        chk("oor_wr_no_mem_wr", wr_cycles, 0);

        // Slow memory: every access completes after 7 cycles.
        lat = 7;
        bus.sd_lba = 32'd5;
        exp_read(27'hA00, 1'b0, 512);
        xfer(3'b001, 3'b000, 2'd0, "slow_rd");
        lat = 1;

        // Reset in the middle of a read, request held across reset.
        bus.sd_lba = 32'd2;
        exp_read(27'h400, 1'b0, 100);
        bus.sd_rd = 3'b001;
        c = 0;
        while (buf_q.size() != 0 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("mid_progress", buf_q.size(), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", bus.sd_ack, 1'b0);
        chk("mid_rst_mem_rd", bus.mem_rd, 1'b0);
        chk("mid_rst_buff_wr", bus.sd_buff_wr, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_mem_left", mem_q.size(), 0);
        @(negedge clk);
        exp_read(27'h400, 1'b0, 512);
        rst_n = 1'b1;
        wait_ack(1'b1, 50, "restart_ack_rise");
        bus.sd_rd = '0;
        wait_ack(1'b0, 20000, "restart_ack_fall");
        chk("restart_buf_left", buf_q.size(), 0);
        chk("restart_mem_left", mem_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disk_block_responder.md
Name: disk_block_responder

Overview:
- Target side of the sector request handshake (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*).
- Services per-drive block read and write requests from the drive-emulation logic.
- Moves 512-byte sectors between the shared sector buffer and a byte-wide backing-store memory port.
- Used where disk images live in RAM instead of being served by the HPS, and as the bench model of the HPS side.

Parameters:
- VDNUM, 3, number of virtual drives (request bits).
- MEM_AW, 27, backing-store byte address width.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- sd_lba  in  32  sector number, sampled at accept.
- sd_rd  in  VDNUM  per-drive read request, level, held by initiator until sd_ack.
- sd_wr  in  VDNUM  per-drive write request, same rules.
- sd_ack  out  1  transfer in progress.
- sd_buff_addr  out  9  sector buffer byte address.
- sd_buff_dout  out  8  read data to buffer.
- sd_buff_wr  out  1  buffer write strobe, 1-cycle pulse.
- sd_buff_din  in  8  buffer read data; registered RAM, valid 1 cycle after address.
- img_base  in  VDNUM*MEM_AW  per-drive image base byte address, drive i at [i*MEM_AW +: MEM_AW].
- img_blocks  in  VDNUM*32  per-drive image size in sectors.
- mem_addr  out  MEM_AW  backing-store address.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_din  out  8  write data.
- mem_dout  in  8  read data, valid with mem_ready.
- mem_ready  in  1  1-cycle completion of the current mem_rd/mem_wr.
- busy  out  1  FSM not IDLE.
- drv  out  2  drive index of the current/last transfer.

Behaviour:
- Reset (async, RESET_N low): all outputs 0, FSM to IDLE, byte counter 0. Mid-transfer reset aborts immediately; mem strobes drop in the same instant; no completion is signalled.
- Arbitration in IDLE: the lowest drive index with sd_rd or sd_wr set wins; sd_rd beats sd_wr on the same drive.
- Accept: latch drive, direction, sd_lba. Compute base = img_base[drv] + {sd_lba, 9'b0}, truncated to MEM_AW. Set oor = (sd_lba >= img_blocks[drv]), unsigned 32-bit compare.
- sd_ack rises the cycle after accept and stays high until the last byte completes.
- Byte counter n runs 0..511; mem_addr = base + n.
- FSM states: IDLE -> ACCEPT -> (RD_FETCH -> RD_PUT)x512 | (WR_ADDR -> WR_WAIT -> WR_STORE)x512 -> DONE -> IDLE.
- RD_FETCH:
  - If oor: data = 0x00, no memory access.
  - Otherwise: assert mem_rd with stable mem_addr until mem_ready; capture mem_dout on mem_ready; mem_rd drops the next cycle.
- RD_PUT: sd_buff_addr = n, sd_buff_dout = data, sd_buff_wr = 1 for one cycle. Then n+1, or DONE at n = 511.
- WR_ADDR: drive sd_buff_addr = n.
- WR_WAIT: one cycle for buffer read latency; capture sd_buff_din at the end.
- WR_STORE:
  - If oor: drop the byte, no memory access.
  - Otherwise: assert mem_wr with mem_din/mem_addr stable until mem_ready.
  - Then n+1, or DONE at n = 511.
- DONE: sd_ack deasserts. FSM stays in IDLE at least 1 cycle before the next accept, so the initiator sees the ack falling edge.
- Requests arriving while busy are not latched; level hold by the initiator makes them pending. A request bit still high in IDLE after its own transfer (initiator failed to clear) is re-served.
- mem_rd and mem_wr are never high together; a mem_ready with no request pending is ignored.
- Counter wrap: n is 9 bits. Termination is on n == 511 after the final strobe, never on overflow.
- Minimum transfer time with zero-wait memory: read ~1026 cycles, write ~1538 cycles.

Decomposition:
- Shared package disk_pkg: state enum, SECTOR_BYTES = 512, SECTOR_LOG2 = 9.
- One natural sub-module disk_req_arbiter: combinational priority pick of drive and direction from sd_rd/sd_wr. All else stays in the top FSM.

Test Plan:
- Read, drive 0, sd_lba = 2, img_base[0] = 0, img_blocks[0] = 720, memory pattern addr[7:0]^0x5A, mem_ready 1 cycle after request -> mem_addr 0x400..0x5FF in order; 512 sd_buff_wr pulses, addr 0..511 with matching data; sd_ack falls after byte 511.
- Write, drive 1, sd_lba = 0, img_base[1] = 0x100000, buffer preloaded with n[7:0] -> 512 mem_wr at 0x100000+n with mem_din = n[7:0]; no sd_buff_wr.
- sd_rd = 3'b101 at once -> drive 0 served first (drv = 0), initiator clears bit 0 on ack, then drive 2 (drv = 2) after ≥1 idle cycle.
- sd_lba = 720 with img_blocks = 720, read -> 512 bytes of 0x00, mem_rd never asserted. Same for write -> mem_wr never asserted, sd_ack still pulses.
- mem_ready delayed 7 cycles on every access -> mem_rd held with constant mem_addr for 7 cycles; data correct; no byte skipped or duplicated.
- RESET_N low at byte 100 of a read -> sd_ack, mem_rd, sd_buff_wr 0 immediately. After release with the request still high -> full new transfer from n = 0.
